dbg_uart_bridge: RTL and testbench

- Parametrised debug bridge between a byte-stream UART receiver/transmitter and the system memory bus.
- Interprets single-letter commands: status, address load, single and burst byte read/write.
- Generalises address width, bus data width and byte-lane strobes.
- Adds a TX ready handshake, burst transfers and a sticky overflow status.

---
 rtl/dbg_uart_bridge.sv | 267 ++++++++++++++++++++++++++
 tb/tb_dbg_uart_bridge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_uart_bridge.sv
// Debug bridge from a UART byte stream to a byte-addressed memory bus.
// Optional argument timeout: define DBG_UART_TIMEOUT_EN.
module dbg_uart_bridge #(
   parameter int AW  = 16,
   parameter int DW  = 16,
   parameter int TOW = 16
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic            dix,
   input  logic [7:0]      id,
   input  logic            txrdy,
   output logic            dox,
   output logic [7:0]      od,
   output logic [AW-1:0]   addru,
   output logic [DW-1:0]   datau,
   output logic [DW/8-1:0] wru,
   output logic            ru,
   output logic            csu,
   input  logic [DW-1:0]   data
);

   localparam int NL = DW / 8;
   localparam int LB = (NL > 1) ? $clog2(NL) : 1;
   localparam int NB = AW / 8;

   localparam logic [7:0] CMD_STAT = 8'h69;  // "i"
   localparam logic [7:0] CMD_ADDR = 8'h61;  // "a"
   localparam logic [7:0] CMD_WR   = 8'h77;  // "w"
   localparam logic [7:0] CMD_RD   = 8'h72;  // "r"
   localparam logic [7:0] CMD_BWR  = 8'h57;  // "W"
   localparam logic [7:0] CMD_BRD  = 8'h52;  // "R"

   typedef enum logic [2:0] {
      IDLE, ADDR, WDATA, LEN, BWRITE, RDMEM, RDCAP, TXWAIT
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [2:0]      acnt_q, acnt_d;
   logic [AW-1:0]   shadow_q, shadow_d;
   logic            dir_q, dir_d;
   logic            stat_q, stat_d;
   logic            ovf_q, ovf_d;
   logic            wr_inc_q, wr_inc_d;
   logic            rd_inc_q, rd_inc_d;
   logic            dox_q, dox_d;
   logic [7:0]      od_q, od_d;
   logic [AW-1:0]   addru_q, addru_d;
   logic [DW-1:0]   datau_q, datau_d;
   logic [NL-1:0]   wru_q, wru_d;
   logic            ru_q, ru_d;

   logic [LB-1:0]   lane;
   logic [7:0]      rd_byte;
   logic [7:0]      status;
   logic            drop;
   logic            tmo_hit;

   always_comb begin
      lane    = (NL == 1) ? '0 : addru_q[LB-1:0];
      rd_byte = data[lane*8 +: 8];
      status  = {6'b0, ovf_q, (state_q != IDLE) && (state_q != ADDR)};
      // Bytes arriving while a read is in flight or a write has not finished are lost.
      drop    = dix && ((state_q == RDMEM) || (state_q == RDCAP) ||
                        (state_q == TXWAIT) || wr_inc_q);
   end

`ifdef DBG_UART_TIMEOUT_EN
   logic [TOW-1:0] tmo_q, tmo_d;
   logic           waiting;

   always_comb begin
      waiting = ((state_q == ADDR) || (state_q == WDATA) || (state_q == LEN) ||
                 (state_q == BWRITE)) && !wr_inc_q;
      tmo_hit = waiting && !dix && (&tmo_q);
      tmo_d   = (!waiting || dix || tmo_hit) ? '0 : tmo_q + 1'b1;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) tmo_q <= '0;
      else         tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acnt_d   = acnt_q;
      shadow_d = shadow_q;
      dir_d    = dir_q;
      stat_d   = stat_q;
      ovf_d    = ovf_q;
      wr_inc_d = wr_inc_q;
      rd_inc_d = rd_inc_q;
      dox_d    = 1'b0;
      od_d     = od_q;
      addru_d  = addru_q;
      datau_d  = datau_q;
      wru_d    = '0;
      ru_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (dix) begin
               case (id)
                  CMD_STAT: begin
                     od_d = status;
                     if (txrdy && !dox_q) begin
                        dox_d = 1'b1;
                        ovf_d = 1'b0;
                     end else begin
                        stat_d  = 1'b1;
                        state_d = TXWAIT;
                     end
                  end
                  CMD_ADDR: begin
                     acnt_d  = 3'(NB);
                     state_d = ADDR;
                  end
                  CMD_WR: begin
                     cnt_d   = '0;
                     state_d = WDATA;
                  end
                  CMD_RD: begin
                     cnt_d   = '0;
                     ru_d    = 1'b1;
                     state_d = RDMEM;
                  end
                  CMD_BWR: begin
                     dir_d   = 1'b0;
                     state_d = LEN;
                  end
                  CMD_BRD: begin
                     dir_d   = 1'b1;
                     state_d = LEN;
                  end
                  default: ;
               endcase
            end
         end
         ADDR: begin
            if (dix) begin
               shadow_d = AW'({shadow_q, id});
               if (acnt_q == 3'd1) begin
                  addru_d = shadow_d;
                  state_d = IDLE;
               end else begin
                  acnt_d = acnt_q - 3'd1;
               end
            end
         end
         LEN: begin
            if (dix) begin
               cnt_d = id;
               if (dir_q) begin
                  ru_d    = 1'b1;
                  state_d = RDMEM;
               end else begin
                  state_d = BWRITE;
               end
            end
         end
         WDATA, BWRITE: begin
            // The lane strobe goes out first; the address advances one cycle later.
            if (wr_inc_q) begin
               wr_inc_d = 1'b0;
               addru_d  = addru_q + 1'b1;
               if (cnt_q == 8'd0) state_d = IDLE;
               else               cnt_d   = cnt_q - 8'd1;
            end else if (dix) begin
               wru_d                 = NL'(1) << lane;
               datau_d[lane*8 +: 8]  = id;
               wr_inc_d              = 1'b1;
            end
         end
         RDMEM: state_d = RDCAP;
         RDCAP: begin
            od_d    = rd_byte;
            stat_d  = 1'b0;
            state_d = TXWAIT;
            if (txrdy) begin
               dox_d    = 1'b1;
               rd_inc_d = 1'b1;
            end
         end
         TXWAIT: begin
            // rd_inc_q marks the cycle after a read byte was handed to the UART.
            if (rd_inc_q) begin
               rd_inc_d = 1'b0;
               addru_d  = addru_q + 1'b1;
               if (cnt_q != 8'd0) begin
                  cnt_d   = cnt_q - 8'd1;
                  ru_d    = 1'b1;
                  state_d = RDMEM;
               end else begin
                  state_d = IDLE;
               end
            end else if (txrdy) begin
               dox_d = 1'b1;
               if (stat_q) begin
                  stat_d  = 1'b0;
                  ovf_d   = 1'b0;
                  state_d = IDLE;
               end else begin
                  rd_inc_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (tmo_hit) begin
         state_d = IDLE;
         cnt_d   = '0;
         ovf_d   = 1'b1;
      end
      if (drop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acnt_q   <= '0;
         shadow_q <= '0;
         dir_q    <= 1'b0;
         stat_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wr_inc_q <= 1'b0;
         rd_inc_q <= 1'b0;
         dox_q    <= 1'b0;
         od_q     <= '0;
         addru_q  <= '0;
         datau_q  <= '0;
         wru_q    <= '0;
         ru_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acnt_q   <= acnt_d;
         shadow_q <= shadow_d;
         dir_q    <= dir_d;
         stat_q   <= stat_d;
         ovf_q    <= ovf_d;
         wr_inc_q <= wr_inc_d;
         rd_inc_q <= rd_inc_d;
         dox_q    <= dox_d;
         od_q     <= od_d;
         addru_q  <= addru_d;
         datau_q  <= datau_d;
         wru_q    <= wru_d;
         ru_q     <= ru_d;
      end
   end

   assign dox   = dox_q;
   assign od    = od_q;
   assign addru = addru_q;
   assign datau = datau_q;
   assign wru   = wru_q;
   assign ru    = ru_q;
   assign csu   = (|wru_q) | ru_q;

endmodule

// File: tb/tb_dbg_uart_bridge.sv
// Directed bench for dbg_uart_bridge at AW=16, DW=16 (default build).
`timescale 1ns/1ps
module tb_dbg_uart_bridge;

   logic        clk;
   logic        nreset;
   logic        dix;
   logic [7:0]  id;
   logic        txrdy;
   logic        dox;
   logic [7:0]  od;
   logic [15:0] addru;
   logic [15:0] datau;
   logic [1:0]  wru;
   logic        ru;
   logic        csu;
   logic [15:0] data;

   int tests;
   int fails;

   dbg_uart_bridge #(.AW(16), .DW(16), .TOW(16)) dut (
      .clk    (clk),
      .nreset (nreset),
      .dix    (dix),
      .id     (id),
      .txrdy  (txrdy),
      .dox    (dox),
      .od     (od),
      .addru  (addru),
      .datau  (datau),
      .wru    (wru),
      .ru     (ru),
      .csu    (csu),
      .data   (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      dix = 1'b1;
      id  = b;
      tick();
      dix = 1'b0;
      id  = 8'h00;
   endtask

   task automatic wait_dox(input string tag, input logic [7:0] exp_od);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (dox) seen = 1'b1;
      end
      check({tag, "_dox"}, {31'b0, seen}, 32'd1);
      if (seen) check({tag, "_od"}, {24'b0, od}, {24'b0, exp_od});
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_dox"},   {31'b0, dox},   32'd0);
      check({tag, "_od"},    {24'b0, od},    32'd0);
      check({tag, "_addru"}, {16'b0, addru}, 32'd0);
      check({tag, "_datau"}, {16'b0, datau}, 32'd0);
      check({tag, "_wru"},   {30'b0, wru},   32'd0);
      check({tag, "_ru"},    {31'b0, ru},    32'd0);
      check({tag, "_csu"},   {31'b0, csu},   32'd0);
   endtask

   logic [15:0] exp_a [3];
   logic [7:0]  exp_o [3];

   initial begin
      tests  = 0;
      fails  = 0;
      nreset = 1'b0;
      dix    = 1'b0;
      id     = 8'h00;
      txrdy  = 1'b1;
      data   = 16'h0000;

      // Reset values
      #23;
      check_idle_outputs("reset");
      nreset = 1'b1;
      tick();

      // Address load then single read at 0x1234 (lane 0)
      send_byte(8'h61); send_byte(8'h12); send_byte(8'h34);
      check("addr_load", {16'b0, addru}, 32'h1234);
      data = 16'hABCD;
      send_byte(8'h72);
      check("rd_ru",  {31'b0, ru},  32'd1);
      check("rd_csu", {31'b0, csu}, 32'd1);
      check("rd_wru", {30'b0, wru}, 32'd0);
      tick();
      check("rd_ru_one_cycle", {31'b0, ru}, 32'd0);
      tick();
      check("rd_dox", {31'b0, dox}, 32'd1);
      check("rd_od",  {24'b0, od},  32'hCD);
      tick();
      check("rd_dox_single", {31'b0, dox}, 32'd0);
      check("rd_addr_inc", {16'b0, addru}, 32'h1235);

      // Single write at 0x1235 (lane 1)
      send_byte(8'h77);
      send_byte(8'h5A);
      check("wr_wru",   {30'b0, wru},   32'h2);
      check("wr_datau", {16'b0, datau}, 32'h5A00);
      check("wr_csu",   {31'b0, csu},   32'd1);
      check("wr_addr_hold", {16'b0, addru}, 32'h1235);
      tick();
      check("wr_wru_one_cycle", {30'b0, wru}, 32'd0);
      check("wr_addr_inc", {16'b0, addru}, 32'h1236);

      // Burst read of 3 bytes across the address wrap, TX held off 5 cycles each
      send_byte(8'h61); send_byte(8'hFF); send_byte(8'hFE);
      data = 16'h4433;
      exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000;
      exp_o[0] = 8'h33;    exp_o[1] = 8'h44;    exp_o[2] = 8'h33;
      txrdy = 1'b0;
      send_byte(8'h52);
      send_byte(8'h02);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("brd%0d_ru", k),   {31'b0, ru},    32'd1);
         check($sformatf("brd%0d_addr", k), {16'b0, addru}, {16'b0, exp_a[k]});
         txrdy = 1'b0;
         repeat (5) begin
            tick();
            check($sformatf("brd%0d_no_dox", k), {31'b0, dox}, 32'd0);
         end
         txrdy = 1'b1;
         wait_dox($sformatf("brd%0d", k), exp_o[k]);
         txrdy = 1'b0;
         tick();
      end
      check("brd_end_addr", {16'b0, addru}, 32'h0001);
      check("brd_end_ru",   {31'b0, ru},    32'd0);
      txrdy = 1'b1;

      // Burst write of 2 bytes at 0x0010
      send_byte(8'h61); send_byte(8'h00); send_byte(8'h10);
      send_byte(8'h57);
      send_byte(8'h01);
      send_byte(8'h11);
      check("bwr0_wru",   {30'b0, wru},   32'h1);
      check("bwr0_datau", {16'b0, datau}, 32'h5A11);
      tick();
      check("bwr0_addr", {16'b0, addru}, 32'h0011);
      send_byte(8'h22);
      check("bwr1_wru",   {30'b0, wru},   32'h2);
      check("bwr1_datau", {16'b0, datau}, 32'h2211);
      tick();
      check("bwr_end_addr", {16'b0, addru}, 32'h0012);

      // Byte ignored in IDLE
      send_byte(8'h78);
      check("ign_wru", {30'b0, wru}, 32'd0);
      check("ign_ru",  {31'b0, ru},  32'd0);
      check("ign_dox", {31'b0, dox}, 32'd0);

      // Overflow: byte arrives during TXWAIT, then status reads
      txrdy = 1'b0;
      send_byte(8'h72);
      tick();
      tick();
      send_byte(8'h55);
      txrdy = 1'b1;
      wait_dox("ovf_rd", 8'h33);
      tick();
      check("ovf_rd_addr", {16'b0, addru}, 32'h0013);
      send_byte(8'h69);
      check("stat1_dox", {31'b0, dox}, 32'd1);
      check("stat1_od",  {24'b0, od},  32'h02);
      tick();
      send_byte(8'h69);
      check("stat2_dox", {31'b0, dox}, 32'd1);
      check("stat2_od",  {24'b0, od},  32'h00);
      tick();

      // Status with TX not ready waits for txrdy
      txrdy = 1'b0;
      send_byte(8'h69);
      check("stat3_wait0", {31'b0, dox}, 32'd0);
      repeat (3) begin
         tick();
         check("stat3_wait", {31'b0, dox}, 32'd0);
      end
      txrdy = 1'b1;
      wait_dox("stat3", 8'h00);
      tick();

      // Asynchronous reset in the middle of a burst write
      send_byte(8'h61); send_byte(8'h00); send_byte(8'h20);
      send_byte(8'h57);
      send_byte(8'h05);
      send_byte(8'h77);
      check("mid_wru", {30'b0, wru}, 32'h1);
      #2;
      nreset = 1'b0;
      #1;
      check_idle_outputs("async_rst");
      #1;
      nreset = 1'b1;
      repeat (3) begin
         tick();
         check("post_rst_wru", {30'b0, wru}, 32'd0);
         check("post_rst_addr", {16'b0, addru}, 32'd0);
      end
      send_byte(8'h99);
      check("post_rst_ign_wru", {30'b0, wru}, 32'd0);
      send_byte(8'h69);
      check("post_rst_stat_dox", {31'b0, dox}, 32'd1);
      check("post_rst_stat_od",  {24'b0, od},  32'h00);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
